// File: rtl/led_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : led_scan_pkg                                               |
// | Brief   : Shared types, default timing constants and helpers for     |
// |           the LED scan controller.                                   |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package led_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam int c_clks_per_col_default = 1000;
    localparam int c_blank_clks_default   = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_scan_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : led_scan_timer                                             |
// | Brief   : Dwell/blank counter: clear on load, count 0..limit while   |
// |           enabled, single-cycle terminal-count pulse.                |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module led_scan_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    assign o_tc = i_en && (r_count == i_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : led_scan_controller                                        |
// | Brief   : Column-scanning LED matrix driver with a one-deep pending  |
// |           frame buffer swapped in at frame boundaries.               |
// |           Define LED_SCAN_BLANKING_EN for an inter-column blank.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module led_scan_controller
    import led_scan_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_COL = c_clks_per_col_default,
    parameter int BLANK_CLKS   = c_blank_clks_default
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               frame_valid,
    input  logic [N*N-1:0]     frame_data,
    output logic               frame_ready,
    output logic               ena,
    output logic [$clog2(N):0] x,
    output logic [N*N-1:0]     cells,
    output logic               frame_start
);

    localparam int c_xw = $clog2(N) + 1;
`ifdef LED_SCAN_BLANKING_EN
    localparam int c_cnt_w = (cnt_width(CLKS_PER_COL) > cnt_width(BLANK_CLKS)) ?
                             cnt_width(CLKS_PER_COL) : cnt_width(BLANK_CLKS);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CLKS - 1);
`else
    localparam int c_cnt_w = cnt_width(CLKS_PER_COL);
`endif
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(CLKS_PER_COL - 1);
    localparam logic [c_xw-1:0]    c_x_last     = c_xw'(N - 1);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("led_scan_controller: N=%0d outside 1..8", N);
    end
    if (CLKS_PER_COL < 1) begin : g_bad_clks
        $error("led_scan_controller: CLKS_PER_COL=%0d must be >= 1", CLKS_PER_COL);
    end
    if (BLANK_CLKS < 1) begin : g_bad_blank
        $error("led_scan_controller: BLANK_CLKS=%0d must be >= 1", BLANK_CLKS);
    end

    scan_state_t        r_state;
    logic [N*N-1:0]     r_pending;
    logic               r_pending_full;

    logic               w_cnt_en;
    logic [c_cnt_w-1:0] w_limit;
    logic               w_tc;
    logic               w_advance;
    logic               w_boundary;
    logic               w_swap;
    logic               w_accept;
    logic [c_xw-1:0]    w_x_next;

    assign w_cnt_en = run && (r_state != IDLE);

`ifdef LED_SCAN_BLANKING_EN
    assign w_limit   = (r_state == BLANK) ? c_blank_last : c_dwell_last;
    assign w_advance = (r_state == BLANK) && w_tc;
`else
    assign w_limit   = c_dwell_last;
    assign w_advance = (r_state == SCAN) && w_tc;
`endif

    assign w_x_next    = (x == c_x_last) ? '0 : x + c_xw'(1);
    assign w_boundary  = w_advance && (x == c_x_last);
    // Swap only on a real transition; run=0 forces IDLE and must not consume the frame.
    assign w_swap      = run && r_pending_full && ((r_state == IDLE) || w_boundary);
    assign w_accept    = frame_valid && !r_pending_full;
    assign frame_ready = ~r_pending_full;

    led_scan_timer #(
        .WIDTH (c_cnt_w)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (~w_cnt_en),
        .i_en    (w_cnt_en),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            ena            <= 1'b0;
            x              <= '0;
            cells          <= '0;
            frame_start    <= 1'b0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            if (w_accept) begin
                r_pending      <= frame_data;
                r_pending_full <= 1'b1;
            end

            if (!run) begin
                r_state <= IDLE;
                ena     <= 1'b0;
                x       <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= SCAN;
                        ena     <= 1'b1;
                    end
                    SCAN: begin
                        if (w_tc) begin
`ifdef LED_SCAN_BLANKING_EN
                            r_state <= BLANK;
                            ena     <= 1'b0;
`else
                            x       <= w_x_next;
`endif
                        end
                    end
`ifdef LED_SCAN_BLANKING_EN
                    BLANK: begin
                        if (w_tc) begin
                            r_state <= SCAN;
                            ena     <= 1'b1;
                            x       <= w_x_next;
                        end
                    end
`endif
                    default: begin
                        r_state <= IDLE;
                        ena     <= 1'b0;
                        x       <= '0;
                    end
                endcase

                if (w_swap) begin
                    cells          <= r_pending;
                    r_pending_full <= 1'b0;
                    frame_start    <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_led_scan_controller                                     |
// | Brief   : Self-checking bench; displayed frames are scoreboarded     |
// |           against the frames offered while frame_ready was high.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_led_scan_controller;

    localparam int N    = 8;
    localparam int CLKS = 4;
`ifdef LED_SCAN_BLANKING_EN
    localparam int PERIOD = 6;
`else
    localparam int PERIOD = 4;
`endif

    localparam logic [63:0] c_f0 = 64'h00FF_00FF_00FF_00FF;
    localparam logic [63:0] c_fa = 64'hA5A5_0F0F_1234_8001;
    localparam logic [63:0] c_fb = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] c_fc = 64'h8040_2010_0804_0201;
    localparam logic [63:0] c_fd = 64'hFFFF_0000_FFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        frame_valid = 1'b0;
    logic [63:0] frame_data = '0;
    logic        frame_ready;
    logic        ena;
    logic [3:0]  x;
    logic [63:0] cells;
    logic        frame_start;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [3:0]  prev_x;

    led_scan_controller #(
        .N            (N),
        .CLKS_PER_COL (CLKS),
        .BLANK_CLKS   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_ready (frame_ready),
        .ena         (ena),
        .x           (x),
        .cells       (cells),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one clock and sample 1 time unit later; every frame_start pops the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_start === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_frame_start", 64'd1, 64'd0);
            else chk("cells_at_frame_start", cells, exp_q.pop_front());
        end
    endtask

    task automatic wait_x(input logic [3:0] v);
        int n = 0;
        while (x !== v && n < 100) begin
            tick();
            n++;
        end
        if (x !== v) chk("wait_x_timeout", 64'(x), 64'(v));
    endtask

    task automatic wait_fs(input int bound, output logic [3:0] last_x);
        int n = 0;
        last_x = x;
        tick();
        while (frame_start !== 1'b1 && n < bound) begin
            last_x = x;
            tick();
            n++;
        end
        if (frame_start !== 1'b1) chk("frame_start_timeout", 64'd0, 64'd1);
    endtask

    task automatic offer(input logic [63:0] d);
        frame_valid = 1'b1;
        frame_data  = d;
        tick();
        frame_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_ena", 64'(ena), 64'd0);
        chk("rst_x", 64'(x), 64'd0);
        chk("rst_cells", cells, 64'd0);
        chk("rst_frame_start", 64'(frame_start), 64'd0);
        chk("rst_frame_ready", 64'(frame_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("idle_ena", 64'(ena), 64'd0);
        chk("idle_x", 64'(x), 64'd0);

        // Frame offered in IDLE is shown on the first SCAN cycle
        offer(c_f0);
        exp_q.push_back(c_f0);
        chk("f0_ready_low", 64'(frame_ready), 64'd0);
        chk("f0_idle_cells", cells, 64'd0);
        chk("f0_idle_no_fs", 64'(frame_start), 64'd0);
        run = 1'b1;
        tick();
        chk("f0_frame_start", 64'(frame_start), 64'd1);
        chk("f0_scan_ena", 64'(ena), 64'd1);
        chk("f0_scan_x", 64'(x), 64'd0);
        tick();
        chk("f0_ready_back", 64'(frame_ready), 64'd1);
        chk("f0_fs_single", 64'(frame_start), 64'd0);

        // A accepted at x=3, B dropped at x=5, A shown at the 7->0 wrap
        wait_x(4'd3);
        chk("a_ready_before", 64'(frame_ready), 64'd1);
        offer(c_fa);
        exp_q.push_back(c_fa);
        chk("a_ready_low", 64'(frame_ready), 64'd0);
        wait_x(4'd5);
        offer(c_fb);
        chk("b_ready_still_low", 64'(frame_ready), 64'd0);
        chk("b_cells_unchanged", cells, c_f0);
        wait_fs(PERIOD * N + 4, prev_x);
        chk("a_wrap_prev_x", 64'(prev_x), 64'd7);
        chk("a_wrap_x", 64'(x), 64'd0);
        chk("a_wrap_ena", 64'(ena), 64'd1);
        tick();
        chk("a_ready_back", 64'(frame_ready), 64'd1);

        // run=0 at x=5 keeps pending frame C until scanning resumes
        wait_x(4'd5);
        offer(c_fc);
        exp_q.push_back(c_fc);
        run = 1'b0;
        tick();
        chk("stop_ena", 64'(ena), 64'd0);
        chk("stop_x", 64'(x), 64'd0);
        chk("stop_cells_kept", cells, c_fa);
        chk("stop_pending_kept", 64'(frame_ready), 64'd0);
        tick();
        tick();
        chk("stop_idle_x", 64'(x), 64'd0);
        chk("stop_idle_ena", 64'(ena), 64'd0);
        run = 1'b1;
        tick();
        chk("c_frame_start", 64'(frame_start), 64'd1);
        chk("c_ena", 64'(ena), 64'd1);
        chk("c_x", 64'(x), 64'd0);
        tick();
        chk("c_ready_back", 64'(frame_ready), 64'd1);

        // Reset mid-scan with frame D pending: immediate, D discarded
        wait_x(4'd2);
        offer(c_fd);
        chk("d_ready_low", 64'(frame_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("arst_ena", 64'(ena), 64'd0);
        chk("arst_x", 64'(x), 64'd0);
        chk("arst_cells", cells, 64'd0);
        chk("arst_frame_ready", 64'(frame_ready), 64'd1);
        chk("arst_frame_start", 64'(frame_start), 64'd0);
        #2;
        rst = 1'b0;
        tick();

        // One full frame of column timing with nothing pending
        for (int k = 0; k <= PERIOD * N; k++) begin
            chk($sformatf("scan_x_k%0d", k), 64'(x), 64'((k / PERIOD) % N));
            chk($sformatf("scan_ena_k%0d", k), 64'(ena), 64'(((k % PERIOD) < CLKS) ? 1 : 0));
            if (k < PERIOD * N) tick();
        end
        chk("scan_cells_zero", cells, 64'd0);
        chk("scan_no_fs", 64'(frame_start), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
